// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared definitions for the program-counter sequencer slice:
//   opcode encoding, sequencer state encoding and an opcode decode helper.
//   Imported by pc_seq.

package pc_seq_pkg;

  typedef enum logic [2:0] {
    INC  = 3'd0,
    JMP  = 3'd1,
    BRR  = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4
  } op_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  // Unassigned codes 5..7 behave as INC, so they are folded in here and
  // the rest of the design only ever sees legal enum values.
  function automatic op_t decode_op(input logic [2:0] code);
    op_t result;
    case (code)
      3'd1:    result = JMP;
      3'd2:    result = BRR;
      3'd3:    result = CALL;
      3'd4:    result = RET;
      default: result = INC;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if
//   Command/status bundle of the program-counter sequencer.
//   master modport (command source): drives en, op, din, clr_fault;
//                                    observes dout, stack_full, stack_empty, fault.
//   slave modport  (pc_seq)        : the mirror image.
//   en          advance enable (0 = hold everything)
//   op          3-bit opcode (INC/JMP/BRR/CALL/RET, 5-7 = INC)
//   din         jump/call target or signed branch offset
//   clr_fault   leave the FAULT state
//   dout        registered program counter
//   stack_full  return stack holds DEPTH entries
//   stack_empty return stack holds no entries
//   fault       sequencer is in the FAULT state

interface pc_seq_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic             clr_fault;
  logic [WIDTH-1:0] dout;
  logic             stack_full;
  logic             stack_empty;
  logic             fault;

  modport master (
    output en, op, din, clr_fault,
    input  dout, stack_full, stack_empty, fault
  );

  modport slave (
    input  en, op, din, clr_fault,
    output dout, stack_full, stack_empty, fault
  );

endinterface

// File: rtl/pc_ret_stack.sv
// pc_ret_stack
//   LIFO return-address stack for pc_seq.
//   clk, rst_n  clock and asynchronous active-low reset (clears the pointer)
//   push        write push_data at the current pointer, pointer+1 (ignored when full)
//   pop         pointer-1 (ignored when empty)
//   push_data   return address to store
//   top         most recently pushed entry, forced to 0 when empty
//   full        pointer == DEPTH
//   empty       pointer == 0

module pc_ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_m1;

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);
  assign sp_m1 = sp - SPW'(1);

  // Only the pointer is reset: entries above it are meaningless, and
  // clearing sp is enough to discard a push/pop interrupted by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  // Storage array, written at the slot the pointer currently addresses.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= push_data;
    end
  end

  // An empty stack never exposes a stale slot.
  assign top = empty ? '0 : mem[sp_m1[AW-1:0]];

endmodule

// File: rtl/pc_seq.sv
// pc_seq
//   Program-counter sequencer with INC / JMP / relative branch / CALL / RET
//   and a return stack. Stack overflow or underflow parks the sequencer in
//   FAULT until clr_fault is seen.
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (dout=RESET_VEC, stack empty, RUN)
//   bus    pc_seq_if slave: en, op, din, clr_fault in; dout, stack_full,
//          stack_empty, fault out

module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic    clk,
  input  logic    rst_n,
  pc_seq_if.slave bus
);

  state_t           state;
  state_t           state_next;
  op_t              op_dec;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stack_top;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign op_dec = decode_op(bus.op);
  assign pc_inc = pc + WIDTH'(1);

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .full      (full),
    .empty     (empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: an illegal CALL/RET faults; only clr_fault recovers, and
  // the op present on the recovery edge is not executed.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (bus.en && op_dec == CALL && full) begin
          state_next = FAULT;
        end else if (bus.en && op_dec == RET && empty) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        if (bus.clr_fault) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Outputs of the FSM: next PC selection and stack control. Illegal
  // CALL/RET leave the PC where it is.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    if (state == RUN && bus.en) begin
      case (op_dec)
        INC: pc_next = pc_inc;
        JMP: pc_next = bus.din;
        // Same-width add is the sign-extended add modulo 2^WIDTH.
        BRR: pc_next = pc + bus.din;
        CALL: begin
          if (!full) begin
            push    = 1'b1;
            pc_next = bus.din;
          end
        end
        RET: begin
          if (!empty) begin
            pop     = 1'b1;
            pc_next = stack_top;
          end
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_next;
    end
  end

  assign bus.dout        = pc;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.fault       = (state == FAULT);

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq
//   Directed self-checking bench for pc_seq (WIDTH=8, DEPTH=4, RESET_VEC=0).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_pc_seq;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  pc_seq_if #(.WIDTH(8)) bus ();

  pc_seq #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VEC (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic [7:0] din,
                       input logic clr);
    bus.en        = en;
    bus.op        = op;
    bus.din       = din;
    bus.clr_fault = clr;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.dout !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_dout: got %h expected 00", bus.dout);
    end
    tests_run++;
    if ({bus.stack_empty, bus.stack_full, bus.fault} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got e/f/flt=%b expected 100",
               {bus.stack_empty, bus.stack_full, bus.fault});
    end
  endtask

  task automatic test_inc();
    logic [7:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'd0, 8'h00, 1'b0);
      tick();
      exp_pc = 8'(i);
      tests_run++;
      if (bus.dout !== exp_pc) begin
        tests_failed++;
        $display("[TB] FAIL inc_%0d: got %h expected %h", i, bus.dout, exp_pc);
      end
    end
    drive(1'b1, 3'd1, 8'hFF, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL jmp_ff: got %h expected ff", bus.dout);
    end
    drive(1'b1, 3'd0, 8'h00, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL inc_wrap: got %h expected 00", bus.dout);
    end
    // Unused opcode 6 behaves as INC.
    drive(1'b1, 3'd6, 8'h55, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL op6_as_inc: got %h expected 01", bus.dout);
    end
  endtask

  task automatic test_brr();
    drive(1'b1, 3'd1, 8'h10, 1'b0);
    tick();
    drive(1'b1, 3'd2, 8'hFC, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h0C) begin
      tests_failed++;
      $display("[TB] FAIL brr_back: got %h expected 0c", bus.dout);
    end
    drive(1'b1, 3'd2, 8'h05, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h11) begin
      tests_failed++;
      $display("[TB] FAIL brr_fwd: got %h expected 11", bus.dout);
    end
  endtask

  task automatic test_call_ret();
    drive(1'b1, 3'd1, 8'h20, 1'b0);
    tick();
    drive(1'b1, 3'd3, 8'h80, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h80 || bus.stack_empty !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL call: got dout=%h empty=%b expected 80/0", bus.dout, bus.stack_empty);
    end
    drive(1'b1, 3'd0, 8'h00, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h81) begin
      tests_failed++;
      $display("[TB] FAIL call_inc: got %h expected 81", bus.dout);
    end
    drive(1'b1, 3'd4, 8'h00, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h21 || bus.stack_empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ret: got dout=%h empty=%b expected 21/1", bus.dout, bus.stack_empty);
    end
  endtask

  task automatic test_stack_full();
    logic [7:0] exp_ret [4];
    exp_ret[0] = 8'h71;
    exp_ret[1] = 8'h61;
    exp_ret[2] = 8'h51;
    exp_ret[3] = 8'h41;
    do_reset();
    drive(1'b1, 3'd1, 8'h40, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd3, 8'(8'h50 + 8'(16 * i)), 1'b0);
      tick();
    end
    tests_run++;
    if (bus.dout !== 8'h80 || bus.stack_full !== 1'b1 || bus.fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL four_calls: got dout=%h full=%b fault=%b expected 80/1/0",
               bus.dout, bus.stack_full, bus.fault);
    end
    drive(1'b1, 3'd3, 8'h90, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h80 || bus.fault !== 1'b1 || bus.stack_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overflow: got dout=%h fault=%b full=%b expected 80/1/1",
               bus.dout, bus.fault, bus.stack_full);
    end
    drive(1'b1, 3'd0, 8'h00, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h80 || bus.fault !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fault_hold: got dout=%h fault=%b expected 80/1", bus.dout, bus.fault);
    end
    // RET on the recovery edge must be ignored.
    drive(1'b1, 3'd4, 8'h00, 1'b1);
    tick();
    tests_run++;
    if (bus.dout !== 8'h80 || bus.fault !== 1'b0 || bus.stack_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clr_fault: got dout=%h fault=%b full=%b expected 80/0/1",
               bus.dout, bus.fault, bus.stack_full);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd4, 8'h00, 1'b0);
      tick();
      tests_run++;
      if (bus.dout !== exp_ret[i]) begin
        tests_failed++;
        $display("[TB] FAIL lifo_ret_%0d: got %h expected %h", i, bus.dout, exp_ret[i]);
      end
    end
    tests_run++;
    if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drained: got empty=%b full=%b expected 1/0",
               bus.stack_empty, bus.stack_full);
    end
  endtask

  task automatic test_ret_empty();
    do_reset();
    drive(1'b1, 3'd4, 8'h00, 1'b0);
    tick();
    tests_run++;
    if (bus.fault !== 1'b1 || bus.dout !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL underflow: got fault=%b dout=%h expected 1/00", bus.fault, bus.dout);
    end
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 3'd1, 8'h33, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h00 || bus.fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL en_low_hold: got dout=%h fault=%b expected 00/0", bus.dout, bus.fault);
    end
    // clr_fault while running does nothing extra; the INC still executes.
    drive(1'b1, 3'd0, 8'h00, 1'b1);
    tick();
    tests_run++;
    if (bus.dout !== 8'h01 || bus.fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_in_run: got dout=%h fault=%b expected 01/0", bus.dout, bus.fault);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'd1, 8'h10, 1'b0);
    tick();
    drive(1'b1, 3'd3, 8'h30, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h30 || bus.stack_empty !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_call: got dout=%h empty=%b expected 30/0",
               bus.dout, bus.stack_empty);
    end
    drive(1'b1, 3'd3, 8'h50, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.dout !== 8'h00 || bus.stack_empty !== 1'b1 || bus.fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got dout=%h empty=%b fault=%b expected 00/1/0",
               bus.dout, bus.stack_empty, bus.fault);
    end
    #2;
    rst_n = 1'b1;
    drive(1'b1, 3'd0, 8'h00, 1'b0);
    tick();
    tests_run++;
    if (bus.dout !== 8'h01 || bus.stack_empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL first_after_reset: got dout=%h empty=%b expected 01/1",
               bus.dout, bus.stack_empty);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    test_reset();
    test_inc();
    test_brr();
    test_call_ret();
    test_stack_full();
    test_ret_empty();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
